// File: rtl/uart_rx_top.sv
// Oversampling UART receiver for 8N1 / 8E1 / 8O1 frames.
// The serial line is synchronised, then each bit is resolved by a 3-sample
// majority vote around mid-bit. Good frames load p_data and pulse valid_data.
module uart_rx_top #(
    parameter int PRESCALE = 16,
    parameter int DATA_W   = 8
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic              data,
    input  logic              parity_en,
    input  logic              parity_type,
    output logic [DATA_W-1:0] p_data,
    output logic              valid_data
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] MID_LO = CNT_W'(PRESCALE / 2 - 1);
    localparam logic [CNT_W-1:0] MID    = CNT_W'(PRESCALE / 2);
    localparam logic [CNT_W-1:0] DEC    = CNT_W'(PRESCALE / 2 + 1);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HI
    } state_t;

    state_t             state;
    logic               sync_1;
    logic               s_data;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_idx;
    logic [DATA_W-1:0]  shreg;
    logic               samp_lo;
    logic               samp_mid;
    logic               maj;
    logic               par_en_q;
    logic               par_type_q;
    logic               par_err;
    logic               par_exp;

    // Two-flop synchroniser bringing the asynchronous line into the clk2 domain
    always_ff @(posedge clk2) begin
        if (rst) begin
            sync_1 <= 1'b1;
            s_data <= 1'b1;
        end else begin
            sync_1 <= data;
            s_data <= sync_1;
        end
    end

    // Majority of the two stored mid-bit samples and the current sample
    assign maj = (samp_lo & samp_mid) | (samp_lo & s_data) | (samp_mid & s_data);

    // Parity bit the sender should have appended for the bits collected so far
    assign par_exp = par_type_q ? (^shreg) : ~(^shreg);

    // Receive FSM: bit timing, sampling, shifting, frame checks and output load
    always_ff @(posedge clk2) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            samp_lo    <= 1'b1;
            samp_mid   <= 1'b1;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            par_err    <= 1'b0;
            p_data     <= '0;
            valid_data <= 1'b0;
        end else begin
            valid_data <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                if (!s_data) begin
                    state      <= START;
                    cnt        <= CNT_W'(1);
                    bit_idx    <= '0;
                    par_en_q   <= parity_en;
                    par_type_q <= parity_type;
                    par_err    <= 1'b0;
                end
            end else if (state == WAIT_HI) begin
                cnt <= '0;
                if (s_data) begin
                    state <= IDLE;
                end
            end else begin
                cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);

                if (cnt == MID_LO) begin
                    samp_lo <= s_data;
                end
                if (cnt == MID) begin
                    samp_mid <= s_data;
                end

                if (cnt == LAST) begin
                    case (state)
                        START: begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                        DATA: begin
                            if (bit_idx == LAST_BIT) begin
                                state <= par_en_q ? PARITY : STOP;
                            end else begin
                                bit_idx <= bit_idx + BIT_W'(1);
                            end
                        end
                        PARITY: begin
                            state <= STOP;
                        end
                        default: begin
                        end
                    endcase
                end

                if (cnt == DEC) begin
                    case (state)
                        START: begin
                            if (maj) begin
                                state <= IDLE;
                                cnt   <= '0;
                            end
                        end
                        DATA: begin
                            shreg <= {maj, shreg[DATA_W-1:1]};
                        end
                        PARITY: begin
                            par_err <= (maj != par_exp);
                        end
                        STOP: begin
                            cnt <= '0;
                            if (maj && !par_err) begin
                                p_data     <= shreg;
                                valid_data <= 1'b1;
                                state      <= IDLE;
                            end else if (maj) begin
                                state <= IDLE;
                            end else begin
                                state <= WAIT_HI;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed testbench for uart_rx_top: frames with hand-computed results,
// parity and framing errors, glitch rejection and reset mid-frame.
module tb_uart_rx_top;

    localparam int BIT_CYC = 16;

    logic       clk2;
    logic       rst;
    logic       data;
    logic       parity_en;
    logic       parity_type;
    logic [7:0] p_data;
    logic       valid_data;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int pulses     = 0;
    int pulse_cyc  = -1;
    int fall_cyc   = 0;
    int base;

    uart_rx_top #(.PRESCALE(16), .DATA_W(8)) dut (
        .clk2        (clk2),
        .rst         (rst),
        .data        (data),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .p_data      (p_data),
        .valid_data  (valid_data)
    );

    // Free-running receive clock, 10 time units per cycle
    initial begin
        clk2 = 1'b0;
        forever #5 clk2 = ~clk2;
    end

    // Cycle counter plus a pulse monitor sampling just after each rising edge
    always @(posedge clk2) begin
        cyc = cyc + 1;
        #1;
        if (valid_data === 1'b1) begin
            pulses    = pulses + 1;
            pulse_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared = compared + 1;
        assert (observed === expected) else begin
            mismatched = mismatched + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic hold_bit(input logic b);
        data = b;
        repeat (BIT_CYC) @(negedge clk2);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic use_par, input logic pbit, input logic stopb);
        data     = 1'b0;
        fall_cyc = cyc;
        repeat (BIT_CYC) @(negedge clk2);
        for (int i = 0; i < 8; i++) begin
            hold_bit(b[i]);
        end
        if (use_par) begin
            hold_bit(pbit);
        end
        hold_bit(stopb);
        data = 1'b1;
    endtask

    initial begin
        rst         = 1'b1;
        data        = 1'b1;
        parity_en   = 1'b0;
        parity_type = 1'b0;
        repeat (2) @(posedge clk2);
        @(negedge clk2);
        rst = 1'b0;

        check("reset_p_data", 32'(p_data), 32'h00);
        check("reset_valid", 32'(valid_data), 32'h0);
        repeat (40) @(negedge clk2);
        check("idle_no_pulse", 32'(pulses), 32'd0);

        // Even parity FF, then odd parity FE back-to-back with no idle gap
        parity_en   = 1'b1;
        parity_type = 1'b1;
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        check("even_pulse", 32'(pulses), 32'd1);
        check("even_p_data", 32'(p_data), 32'hFF);
        check("even_latency", 32'(pulse_cyc - fall_cyc), 32'd172);

        parity_type = 1'b0;
        send_frame(8'hFE, 1'b1, 1'b0, 1'b1);
        check("odd_pulse", 32'(pulses), 32'd2);
        check("odd_p_data", 32'(p_data), 32'hFE);
        check("odd_latency", 32'(pulse_cyc - fall_cyc), 32'd172);
        repeat (20) @(negedge clk2);

        // Parity errors leave p_data untouched
        parity_type = 1'b1;
        send_frame(8'hFD, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk2);
        check("perr_even_pulse", 32'(pulses), 32'd2);
        check("perr_even_p_data", 32'(p_data), 32'hFE);

        parity_type = 1'b0;
        send_frame(8'hFE, 1'b1, 1'b1, 1'b1);
        repeat (20) @(negedge clk2);
        check("perr_odd_pulse", 32'(pulses), 32'd2);
        check("perr_odd_p_data", 32'(p_data), 32'hFE);

        // No parity, latency measured from the pin (154 + 2 synchroniser cycles)
        parity_en = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        check("nopar_pulse", 32'(pulses), 32'd3);
        check("nopar_p_data", 32'(p_data), 32'hA5);
        check("nopar_latency", 32'(pulse_cyc - fall_cyc), 32'd156);
        repeat (20) @(negedge clk2);

        // Short low glitch must not start a frame
        data = 1'b0;
        repeat (4) @(negedge clk2);
        data = 1'b1;
        repeat (200) @(negedge clk2);
        check("glitch_pulse", 32'(pulses), 32'd3);
        check("glitch_p_data", 32'(p_data), 32'hA5);

        // Framing error followed by a long break, then recovery
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        data = 1'b0;
        repeat (50 * BIT_CYC) @(negedge clk2);
        check("break_pulse", 32'(pulses), 32'd3);
        data = 1'b1;
        repeat (32) @(negedge clk2);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        check("recover_pulse", 32'(pulses), 32'd4);
        check("recover_p_data", 32'(p_data), 32'h5A);
        repeat (20) @(negedge clk2);

        // Reset in the middle of a frame aborts it
        base = pulses;
        data = 1'b0;
        repeat (BIT_CYC) @(negedge clk2);
        data = 1'b1;
        repeat (3 * BIT_CYC) @(negedge clk2);
        rst = 1'b1;
        repeat (2) @(negedge clk2);
        rst = 1'b0;
        repeat (200) @(negedge clk2);
        check("rst_mid_pulse", 32'(pulses - base), 32'd0);
        check("rst_mid_p_data", 32'(p_data), 32'h00);

        // Good even-parity frame after the reset
        parity_en   = 1'b1;
        parity_type = 1'b1;
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        check("final_pulse", 32'(pulses - base), 32'd1);
        check("final_p_data", 32'(p_data), 32'h81);
        repeat (20) @(negedge clk2);
        check("final_single_pulse", 32'(pulses - base), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
